// File: rtl/icache_miss_queue_pkg.sv
// Shared constants, entry-state encoding and index helpers for the icache miss queue.
package icache_miss_queue_pkg;

  localparam int unsigned NumWarp    = 4;
  localparam int unsigned NumWarpLog = 2;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned LineOffW   = 6;
  localparam int unsigned LineWidth  = AddrWidth - LineOffW;

  typedef enum logic [1:0] {
    MqFree    = 2'd0,
    MqPending = 2'd1,
    MqIssued  = 2'd2
  } mq_state_e;

  function automatic logic [NumWarp-1:0] idx_to_oh(input logic [NumWarpLog-1:0] idx);
    logic [NumWarp-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/icache_miss_queue_if.sv
// Miss, L2 request/response and wake signals between ifetch, L2 and the miss queue.
interface icache_miss_queue_if;
  import icache_miss_queue_pkg::*;

  logic                    ifd_cache_miss;
  logic [AddrWidth-1:0]    ifd_cache_miss_addr;
  logic [NumWarpLog-1:0]   ifd_cache_miss_warp_idx;
  logic                    mq_to_l2_req_valid;
  logic                    mq_to_l2_req_ready;
  logic [LineWidth-1:0]    mq_to_l2_req_line;
  logic [NumWarpLog-1:0]   mq_to_l2_req_id;
  logic                    l2_to_mq_resp_valid;
  logic [NumWarpLog-1:0]   l2_to_mq_resp_id;
  logic [NumWarp-1:0]      l2i_to_ift_wake_bitmap;
  logic                    mq_err;

  modport slave (
    input  ifd_cache_miss, ifd_cache_miss_addr, ifd_cache_miss_warp_idx,
    input  mq_to_l2_req_ready, l2_to_mq_resp_valid, l2_to_mq_resp_id,
    output mq_to_l2_req_valid, mq_to_l2_req_line, mq_to_l2_req_id,
    output l2i_to_ift_wake_bitmap, mq_err
  );

  modport master (
    output ifd_cache_miss, ifd_cache_miss_addr, ifd_cache_miss_warp_idx,
    output mq_to_l2_req_ready, l2_to_mq_resp_valid, l2_to_mq_resp_id,
    input  mq_to_l2_req_valid, mq_to_l2_req_line, mq_to_l2_req_id,
    input  l2i_to_ift_wake_bitmap, mq_err
  );

endinterface

// File: rtl/icache_miss_queue_entry.sv
// One miss-queue entry: state, line address, waiter bitmap and line-match compare.
module icache_miss_queue_entry
  import icache_miss_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_i,
  input  logic                 merge_i,
  input  logic                 issue_i,
  input  logic                 free_i,
  input  logic [LineWidth-1:0] line_i,
  input  logic [NumWarp-1:0]   warp_oh_i,
  output mq_state_e            state_o,
  output logic [LineWidth-1:0] line_o,
  output logic [NumWarp-1:0]   waiters_o,
  output logic                 match_o
);

  mq_state_e            state_q, state_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic [NumWarp-1:0]   waiters_q, waiters_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MqFree;
      line_q    <= '0;
      waiters_q <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      waiters_q <= waiters_d;
    end
  end

  // Free wins over a same-cycle merge: the merged warp is carried by the wake pulse instead.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    waiters_d = waiters_q;
    if (alloc_i) begin
      state_d   = MqPending;
      line_d    = line_i;
      waiters_d = warp_oh_i;
    end else if (free_i) begin
      state_d   = MqFree;
      waiters_d = '0;
    end else begin
      if (issue_i) state_d = MqIssued;
      if (merge_i) waiters_d = waiters_q | warp_oh_i;
    end
  end

  assign state_o   = state_q;
  assign line_o    = line_q;
  assign waiters_o = waiters_q;
  assign match_o   = (state_q != MqFree) && (line_q == line_i);

endmodule

// File: rtl/icache_miss_queue.sv
// Instruction-cache miss queue: merges same-line misses, round-robin issues L2 fills,
// and pulses the waiter bitmap of each completed fill back to the tag stage.
module icache_miss_queue
  import icache_miss_queue_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  icache_miss_queue_if.slave mq_io
);

  mq_state_e            state   [NumWarp];
  logic [LineWidth-1:0] line    [NumWarp];
  logic [NumWarp-1:0]   waiters [NumWarp];
  logic [NumWarp-1:0]   match, pending, issued, free_vec;
  logic [NumWarp-1:0]   alloc, merge, issue, free_en;

  logic [LineWidth-1:0]  miss_line;
  logic [NumWarp-1:0]    miss_oh;
  logic                  unused_addr_bits;

  logic [NumWarpLog-1:0] rr_q, rr_d, rr_idx, rr_cand, gnt_idx;
  logic                  rr_found;
  logic                  hold_q, hold_d;
  logic [NumWarpLog-1:0] hold_idx_q, hold_idx_d;
  logic [NumWarp-1:0]    wake_q, wake_d;
  logic                  err_q, err_d, err_set;
  logic                  dup, free_found, req_valid, handshake;
  logic [NumWarpLog-1:0] free_idx;

  assign miss_line        = mq_io.ifd_cache_miss_addr[AddrWidth-1:LineOffW];
  assign unused_addr_bits = ^mq_io.ifd_cache_miss_addr[LineOffW-1:0];
  assign miss_oh          = idx_to_oh(mq_io.ifd_cache_miss_warp_idx);

  for (genvar g = 0; g < NumWarp; g++) begin : g_entry
    icache_miss_queue_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_i   (alloc[g]),
      .merge_i   (merge[g]),
      .issue_i   (issue[g]),
      .free_i    (free_en[g]),
      .line_i    (miss_line),
      .warp_oh_i (miss_oh),
      .state_o   (state[g]),
      .line_o    (line[g]),
      .waiters_o (waiters[g]),
      .match_o   (match[g])
    );
    assign pending[g]  = (state[g] == MqPending);
    assign issued[g]   = (state[g] == MqIssued);
    assign free_vec[g] = (state[g] == MqFree);
  end

  // Round-robin pick starting at rr_q; a stalled grant is pinned via hold_q.
  always_comb begin
    rr_idx   = rr_q;
    rr_cand  = rr_q;
    rr_found = 1'b0;
    for (int k = 0; k < NumWarp; k++) begin
      rr_cand = rr_q + NumWarpLog'(k);
      if (!rr_found && pending[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    dup        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NumWarp - 1; k >= 0; k--) begin
      if (free_vec[k]) begin
        free_found = 1'b1;
        free_idx   = NumWarpLog'(k);
      end
      if (|(waiters[k] & miss_oh)) dup = 1'b1;
    end
  end

  assign req_valid = |pending;
  assign gnt_idx   = hold_q ? hold_idx_q : rr_idx;
  assign handshake = req_valid && mq_io.mq_to_l2_req_ready;

  always_comb begin
    alloc      = '0;
    merge      = '0;
    issue      = '0;
    free_en    = '0;
    err_set    = 1'b0;
    wake_d     = '0;
    rr_d       = rr_q;
    hold_d     = req_valid && !mq_io.mq_to_l2_req_ready;
    hold_idx_d = gnt_idx;

    if (mq_io.ifd_cache_miss) begin
      if (dup)             err_set = 1'b1;
      else if (|match)     merge = match;
      else if (free_found) alloc[free_idx] = 1'b1;
      else                 err_set = 1'b1;
    end

    if (mq_io.l2_to_mq_resp_valid) begin
      if (issued[mq_io.l2_to_mq_resp_id]) begin
        free_en[mq_io.l2_to_mq_resp_id] = 1'b1;
        wake_d = waiters[mq_io.l2_to_mq_resp_id] |
                 (merge[mq_io.l2_to_mq_resp_id] ? miss_oh : '0);
      end else begin
        err_set = 1'b1;
      end
    end

    if (handshake) begin
      issue[gnt_idx] = 1'b1;
      rr_d           = gnt_idx + 1'b1;
    end

    err_d = err_q | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      wake_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      wake_q     <= wake_d;
      err_q      <= err_d;
    end
  end

  assign mq_io.mq_to_l2_req_valid     = req_valid;
  assign mq_io.mq_to_l2_req_line      = line[gnt_idx];
  assign mq_io.mq_to_l2_req_id        = gnt_idx;
  assign mq_io.l2i_to_ift_wake_bitmap = wake_q;
  assign mq_io.mq_err                 = err_q;

endmodule

// File: tb/tb_icache_miss_queue.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue model.
module tb_icache_miss_queue;
  import icache_miss_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  icache_miss_queue_if mq_if ();

  icache_miss_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mq_io (mq_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int n_hs   = 0;

  // Model: 0 = free, 1 = pending, 2 = issued
  int          m_state [4];
  logic [25:0] m_line  [4];
  logic [3:0]  m_wait  [4];
  int          m_rr, m_hold_id;
  bit          m_hold, m_err;
  logic [3:0]  m_wake;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int m_grant();
    if (m_hold) return m_hold_id;
    for (int k = 0; k < 4; k++)
      if (m_state[(m_rr + k) % 4] == 1) return (m_rr + k) % 4;
    return -1;
  endfunction

  function automatic bit m_waiting(input int w);
    for (int k = 0; k < 4; k++) if (m_wait[k][w]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int g, hit, fr, w, id;
    bit dup;
    logic [25:0] ml;
    logic [3:0] nw;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_state[k] = 0; m_line[k] = '0; m_wait[k] = '0;
      end
      m_rr = 0; m_hold = 1'b0; m_hold_id = 0; m_err = 1'b0; m_wake = '0;
    end else begin
      g  = m_grant();
      nw = '0;
      if (mq_if.ifd_cache_miss) begin
        w = int'(mq_if.ifd_cache_miss_warp_idx);
        ml = mq_if.ifd_cache_miss_addr[31:6];
        dup = 1'b0; hit = -1; fr = -1;
        for (int k = 0; k < 4; k++) begin
          if (m_wait[k][w]) dup = 1'b1;
          if (m_state[k] != 0 && m_line[k] == ml) hit = k;
          if (m_state[k] == 0 && fr < 0) fr = k;
        end
        if (dup) m_err = 1'b1;
        else if (hit >= 0) m_wait[hit][w] = 1'b1;
        else if (fr >= 0) begin
          m_state[fr] = 1; m_line[fr] = ml; m_wait[fr] = 4'b0001 << w;
        end else m_err = 1'b1;
      end
      if (mq_if.l2_to_mq_resp_valid) begin
        id = int'(mq_if.l2_to_mq_resp_id);
        if (m_state[id] == 2) begin
          nw = m_wait[id]; m_state[id] = 0; m_wait[id] = '0;
        end else m_err = 1'b1;
      end
      m_wake = nw;
      if (g >= 0 && mq_if.mq_to_l2_req_ready) begin
        m_state[g] = 2; m_rr = (g + 1) % 4;
      end
      m_hold    = (g >= 0) && !mq_if.mq_to_l2_req_ready;
      m_hold_id = g;
    end
  end

  always @(posedge clk)
    if (rst_n && mq_if.mq_to_l2_req_valid && mq_if.mq_to_l2_req_ready) n_hs++;

  always @(negedge clk) begin : compare
    int g;
    if (chk_en) begin
      g = m_grant();
      chk("req_valid", 32'(mq_if.mq_to_l2_req_valid), 32'(g >= 0));
      if (g >= 0) begin
        chk("req_id", 32'(mq_if.mq_to_l2_req_id), 32'(g));
        chk("req_line", 32'(mq_if.mq_to_l2_req_line), 32'(m_line[g]));
      end
      chk("wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'(m_wake));
      chk("err", 32'(mq_if.mq_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input int w, input logic [31:0] a);
    mq_if.ifd_cache_miss = 1'b1;
    mq_if.ifd_cache_miss_warp_idx = 2'(w);
    mq_if.ifd_cache_miss_addr = a;
    cyc();
    mq_if.ifd_cache_miss = 1'b0;
  endtask

  task automatic do_resp(input int id);
    mq_if.l2_to_mq_resp_valid = 1'b1;
    mq_if.l2_to_mq_resp_id = 2'(id);
    cyc();
    mq_if.l2_to_mq_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs0, g, w;
    mq_if.ifd_cache_miss = 1'b0;
    mq_if.ifd_cache_miss_addr = '0;
    mq_if.ifd_cache_miss_warp_idx = '0;
    mq_if.mq_to_l2_req_ready = 1'b1;
    mq_if.l2_to_mq_resp_valid = 1'b0;
    mq_if.l2_to_mq_resp_id = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(mq_if.mq_to_l2_req_valid), 32'd0);
    chk("rst_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'd0);
    chk("rst_err", 32'(mq_if.mq_err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single miss, issue, fill, wake
    do_miss(2, 32'h1004);
    chk("t1_valid", 32'(mq_if.mq_to_l2_req_valid), 32'd1);
    chk("t1_line", 32'(mq_if.mq_to_l2_req_line), 32'h40);
    chk("t1_id", 32'(mq_if.mq_to_l2_req_id), 32'd0);
    cyc();
    chk("t1_issued", 32'(mq_if.mq_to_l2_req_valid), 32'd0);
    cyc(); cyc(); cyc();
    do_resp(0);
    chk("t1_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b0100);
    cyc();
    chk("t1_wake_pulse", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'd0);

    // Merge of two warps on one line
    hs0 = n_hs;
    do_miss(0, 32'h2000);
    chk("t2_line", 32'(mq_if.mq_to_l2_req_line), 32'h80);
    do_miss(1, 32'h2038);
    cyc(); cyc();
    chk("t2_one_req", 32'(n_hs - hs0), 32'd1);
    do_resp(0);
    chk("t2_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b0011);

    // Back-pressure holds the request stable
    mq_if.mq_to_l2_req_ready = 1'b0;
    hs0 = n_hs;
    do_miss(3, 32'h3000);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 32'(mq_if.mq_to_l2_req_valid), 32'd1);
      chk("t3_line", 32'(mq_if.mq_to_l2_req_line), 32'hC0);
      chk("t3_id", 32'(mq_if.mq_to_l2_req_id), 32'd0);
      cyc();
    end
    mq_if.mq_to_l2_req_ready = 1'b1;
    cyc(); cyc();
    chk("t3_one_hs", 32'(n_hs - hs0), 32'd1);
    do_resp(0);
    chk("t3_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b1000);

    // Response merged with a same-line miss in the same cycle
    do_miss(0, 32'h5000);
    do_miss(1, 32'h2000);
    cyc();
    hs0 = n_hs;
    mq_if.ifd_cache_miss = 1'b1;
    mq_if.ifd_cache_miss_warp_idx = 2'd3;
    mq_if.ifd_cache_miss_addr = 32'h2010;
    do_resp(1);
    mq_if.ifd_cache_miss = 1'b0;
    chk("t5_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b1010);
    chk("t5_no_req", 32'(mq_if.mq_to_l2_req_valid), 32'd0);
    cyc();
    chk("t5_no_hs", 32'(n_hs - hs0), 32'd0);

    // Reset with outstanding fills, then a stray response
    do_miss(1, 32'h8000);
    cyc();
    do_reset();
    chk("t6_valid", 32'(mq_if.mq_to_l2_req_valid), 32'd0);
    chk("t6_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'd0);
    chk("t6_err", 32'(mq_if.mq_err), 32'd0);
    do_resp(0);
    chk("t6_stray_wake", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'd0);
    chk("t6_stray_err", 32'(mq_if.mq_err), 32'd1);
    do_reset();

    // Four distinct lines issued in round-robin order, out-of-order fills
    mq_if.mq_to_l2_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_miss(i, 32'(i) << 8);
    mq_if.mq_to_l2_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", 32'(mq_if.mq_to_l2_req_id), 32'(i));
      cyc();
    end
    do_resp(2);
    chk("t4_wake2", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b0100);
    do_resp(0);
    chk("t4_wake0", 32'(mq_if.l2i_to_ift_wake_bitmap), 32'b0001);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      w = int'($urandom_range(0, 3));
      mq_if.ifd_cache_miss = ($urandom_range(0, 99) < 40) &&
                             (!m_waiting(w) || $urandom_range(0, 19) == 0);
      mq_if.ifd_cache_miss_warp_idx = 2'(w);
      mq_if.ifd_cache_miss_addr = {26'h40 + 26'($urandom_range(0, 5)), 6'($urandom)};
      mq_if.mq_to_l2_req_ready = $urandom_range(0, 1) == 1;
      g = int'($urandom_range(0, 3));
      mq_if.l2_to_mq_resp_valid = ($urandom_range(0, 99) < 30 && m_state[g] == 2) ||
                                  ($urandom_range(0, 99) < 2);
      mq_if.l2_to_mq_resp_id = 2'(g);
      cyc();
    end
    mq_if.ifd_cache_miss = 1'b0;
    mq_if.l2_to_mq_resp_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
